// File: rtl/cpu_core_mc.sv
// Multi-cycle core for the 4-bit-opcode instruction set, running from one external
// single-port memory over a registered req/ack handshake that tolerates any number of wait states.
//
// state  | meaning
// FETCH  | read instruction at pc (request issued here or on entry)
// DECODE | choose data access, execute or halt
// MEMRD  | data read for LD from memory
// EXEC   | single-cycle ALU / branch / immediate LD
// MEMWR  | data write for STR
// HALT   | terminal until reset
module cpu_core_mc #(
  parameter int BUSW     = 32,
  parameter int MINDW    = 12,
  parameter int RINDW    = 4,
  parameter int RESET_PC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             mem_req,
  output logic             mem_we,
  output logic [MINDW-1:0] mem_addr,
  output logic [BUSW-1:0]  mem_wdata,
  input  logic [BUSW-1:0]  mem_rdata,
  input  logic             mem_ack,
  output logic             halted,
  output logic [MINDW-1:0] pc,
  output logic [4:0]       psr
);

  localparam int NREG = 2 ** RINDW;

  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_BRA = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_ROT = 4'd6;
  localparam logic [3:0] OP_SHF = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEMRD, S_EXEC, S_MEMWR, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [BUSW-1:0]   ir_q, ir_d;
  logic [MINDW-1:0]  pc_q, pc_d, pc_inc;
  logic [4:0]        psr_q, psr_d;
  logic              req_q, req_d, we_q, we_d, halted_q, halted_d;
  logic [MINDW-1:0]  addr_q, addr_d;
  logic [BUSW-1:0]   wdata_q, wdata_d;

  logic [BUSW-1:0]   rf [NREG];
  logic              rf_we;
  logic [RINDW-1:0]  rf_waddr;
  logic [BUSW-1:0]   rf_wdata;

  logic [3:0]        op, cc;
  logic              srctype;
  logic [MINDW-1:0]  src, dst;
  logic [BUSW-1:0]   imm, ra, opb;
  logic [4:0]        cnt, mag;

  logic [BUSW-1:0]   alu_res;
  logic              alu_c, alu_wr, take;
  logic [BUSW:0]     wide, ring;

  assign op      = ir_q[BUSW-1 -: 4];
  assign srctype = ir_q[BUSW-5];
  assign cc      = ir_q[BUSW-5 -: 4];
  assign src     = ir_q[2*MINDW-1:MINDW];
  assign dst     = ir_q[MINDW-1:0];
  assign imm     = {{(BUSW-MINDW){1'b0}}, src};
  assign ra      = rf[dst[RINDW-1:0]];
  assign opb     = srctype ? imm : rf[src[RINDW-1:0]];
  assign cnt     = src[4:0];
  assign mag     = cnt[4] ? (5'd0 - cnt) : cnt;
  assign pc_inc  = pc_q + MINDW'(1);

  function automatic logic [4:0] flags_of(input logic [BUSW-1:0] r, input logic c);
    return {~|r, r[BUSW-1], ~r[0], ^r, c};
  endfunction

  // Shifts and rotates use a BUSW+1 wide scratch word so the carry bit falls out of the slice.
  always_comb begin
    alu_res = ra;
    alu_c   = psr_q[0];
    alu_wr  = 1'b0;
    wide    = '0;
    ring    = {psr_q[0], ra};
    case (op)
      OP_LD:  begin alu_res = opb; alu_wr = 1'b1; end
      OP_XOR: begin alu_res = ra ^ opb; alu_c = 1'b0; alu_wr = 1'b1; end
      OP_ADD: begin {alu_c, alu_res} = {1'b0, ra} + {1'b0, opb}; alu_wr = 1'b1; end
      OP_CMP: begin alu_res = ~opb; alu_c = 1'b0; alu_wr = 1'b1; end
      OP_SHF: begin
        alu_wr = 1'b1;
        if (cnt != 5'd0) begin
          if (!cnt[4]) begin
            wide    = {1'b0, ra} << mag;
            alu_res = wide[BUSW-1:0];
            alu_c   = wide[BUSW];
          end else begin
            wide    = {ra, 1'b0} >> mag;
            alu_res = wide[BUSW:1];
            alu_c   = wide[0];
          end
        end
      end
      OP_ROT: begin
        alu_wr = 1'b1;
        if (cnt != 5'd0) begin
          if (!cnt[4]) wide = (ring << mag) | (ring >> (BUSW + 1 - int'(mag)));
          else         wide = (ring >> mag) | (ring << (BUSW + 1 - int'(mag)));
          alu_res = wide[BUSW-1:0];
          alu_c   = wide[BUSW];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (cc)
      4'd0:    take = 1'b1;
      4'd1:    take = psr_q[1];
      4'd2:    take = psr_q[2];
      4'd3:    take = psr_q[0];
      4'd4:    take = psr_q[3];
      4'd5:    take = psr_q[4];
      4'd6:    take = ~psr_q[0];
      4'd7:    take = ~psr_q[3];
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    psr_d    = psr_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    halted_d = halted_q;
    rf_we    = 1'b0;
    rf_waddr = dst[RINDW-1:0];
    rf_wdata = alu_res;
    case (state_q)
      // After a data access the fetch request is held back one cycle to keep an idle gap.
      S_FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LD: begin
            if (!srctype) begin
              state_d = S_MEMRD;
              req_d   = 1'b1;
              we_d    = 1'b0;
              addr_d  = src;
            end else begin
              state_d = S_EXEC;
            end
          end
          OP_STR: begin
            state_d = S_MEMWR;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = dst;
            wdata_d = opb;
          end
          OP_HLT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_MEMRD: begin
        if (mem_ack) begin
          req_d    = 1'b0;
          rf_we    = 1'b1;
          rf_wdata = mem_rdata;
          psr_d    = flags_of(mem_rdata, psr_q[0]);
          pc_d     = pc_inc;
          state_d  = S_FETCH;
        end
      end
      S_MEMWR: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        pc_d = pc_inc;
        if (op == OP_BRA) begin
          if (take) pc_d = dst;
        end else if (alu_wr) begin
          rf_we = 1'b1;
          psr_d = flags_of(alu_res, alu_c);
        end
        state_d = S_FETCH;
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = pc_d;
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      pc_q     <= MINDW'(RESET_PC);
      psr_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      psr_q    <= psr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = halted_q;
  assign pc        = pc_q;
  assign psr       = psr_q;

endmodule
